// File: rtl/data_mem_responder_pkg.sv
// Shared types and constants for the data-memory responder: FSM encodings,
// byte-select and wait-counter widths, default depth, ack/error levels.
package data_mem_responder_pkg;

  localparam int DATA_W       = 32;
  localparam int BYTE_SEL_W   = 4;
  localparam int DATA_MEM_NUM = 1024;
  localparam int WAIT_CNT_W   = 4;

  localparam logic ACK_ON  = 1'b1;
  localparam logic ACK_OFF = 1'b0;
  localparam logic ERR_ON  = 1'b1;
  localparam logic ERR_OFF = 1'b0;

  typedef logic [BYTE_SEL_W-1:0] byte_sel_t;
  typedef logic [WAIT_CNT_W-1:0] wait_cnt_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_ACK  = 2'b10
  } state_t;

endpackage

// File: rtl/data_mem_responder_if.sv
// MEM-stage load/store bus between the pipeline (master) and the data-memory
// responder (slave).
interface data_mem_responder_if;

  // Handshake: the master raises mem_ce_i with we/addr/sel/data and holds all
  // of them stable until it sees mem_ack_o; mem_ack_o is a one-cycle pulse and
  // mem_data_o/mem_err_o are valid only in that cycle. Dropping mem_ce_i before
  // the ack aborts the request. stallreq_o is high while a request is pending.
  logic                              mem_ce_i;
  logic                              mem_we_i;
  logic [31:0]                       mem_addr_i;
  data_mem_responder_pkg::byte_sel_t mem_sel_i;
  logic [31:0]                       mem_data_i;
  logic [31:0]                       mem_data_o;
  logic                              mem_ack_o;
  logic                              stallreq_o;
  logic                              mem_err_o;

  modport master (
    output mem_ce_i, mem_we_i, mem_addr_i, mem_sel_i, mem_data_i,
    input  mem_data_o, mem_ack_o, stallreq_o, mem_err_o
  );

  modport slave (
    input  mem_ce_i, mem_we_i, mem_addr_i, mem_sel_i, mem_data_i,
    output mem_data_o, mem_ack_o, stallreq_o, mem_err_o
  );

endinterface

// File: rtl/data_mem_responder_array.sv
// Single-port 32-bit RAM with four byte write-enables and a registered read
// port; the read register can be cleared to zero for rejected accesses.
module data_mem_array
  import data_mem_responder_pkg::*;
#(
  parameter int DEPTH = DATA_MEM_NUM
) (
  input  logic                     clk,
  input  logic                     rst,
  input  byte_sel_t                we_i,
  input  logic                     re_i,
  input  logic                     clr_i,
  input  logic [$clog2(DEPTH)-1:0] addr_i,
  input  logic [DATA_W-1:0]        wdata_i,
  output logic [DATA_W-1:0]        rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] rdata_d;

  // Storage is deliberately not reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    for (int b = 0; b < BYTE_SEL_W; b++) begin
      if (we_i[b]) begin
        mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (clr_i) begin
      rdata_d = '0;
    end else if (re_i) begin
      rdata_d = mem_q[addr_i];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: wait-state FSM, stall request and ack generation in
// front of data_mem_array. Optional range check: DATA_MEM_BOUND_CHECK_EN.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int DEPTH       = DATA_MEM_NUM,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  data_mem_responder_if.slave   bus,
  output state_t                dbg_state_o
);

  localparam int AW = $clog2(DEPTH);

  state_t    state_q, state_d;
  wait_cnt_t cnt_q, cnt_d;
  logic      ack_q, ack_d;
  logic      err_q, err_d;

  logic          access;
  logic          oor;
  logic          stall;
  logic [AW-1:0] word_idx;
  byte_sel_t     arr_we;
  logic          arr_re;
  logic          arr_clr;
  logic [31:0]   arr_rdata;

  assign word_idx = bus.mem_addr_i[AW+1:2];

`ifdef DATA_MEM_BOUND_CHECK_EN
  assign oor = (bus.mem_addr_i >> (AW + 2)) != 32'd0;
  logic [1:0] unused_addr;
  assign unused_addr = bus.mem_addr_i[1:0];
`else
  // High address bits simply wrap onto the array.
  assign oor = 1'b0;
  logic [31-AW:0] unused_addr;
  assign unused_addr = {bus.mem_addr_i[31:AW+2], bus.mem_addr_i[1:0]};
`endif

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ack_q   <= ACK_OFF;
      err_q   <= ERR_OFF;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.mem_ce_i) begin
          if (WAIT_CYCLES == 0) begin
            state_d = ST_ACK;
          end else begin
            cnt_d   = wait_cnt_t'(WAIT_CYCLES);
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (!bus.mem_ce_i) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == wait_cnt_t'(1)) begin
          state_d = ST_ACK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - wait_cnt_t'(1);
        end
      end
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic: the access edge is the one that enters ACK
  always_comb begin
    access  = bus.mem_ce_i &&
              (((state_q == ST_IDLE) && (WAIT_CYCLES == 0)) ||
               ((state_q == ST_WAIT) && (cnt_q == wait_cnt_t'(1))));
    stall   = bus.mem_ce_i && (state_q != ST_ACK);
    arr_we  = (access && bus.mem_we_i && !oor) ? bus.mem_sel_i : '0;
    arr_re  = access && !bus.mem_we_i && !oor;
    arr_clr = access && oor;
    ack_d   = access ? ACK_ON : ACK_OFF;
    err_d   = (access && oor) ? ERR_ON : ERR_OFF;
  end

  data_mem_array #(
    .DEPTH (DEPTH)
  ) u_array (
    .clk     (clk),
    .rst     (rst),
    .we_i    (arr_we),
    .re_i    (arr_re),
    .clr_i   (arr_clr),
    .addr_i  (word_idx),
    .wdata_i (bus.mem_data_i),
    .rdata_o (arr_rdata)
  );

  assign bus.mem_data_o = arr_rdata;
  assign bus.mem_ack_o  = ack_q;
  assign bus.stallreq_o = stall;
  assign bus.mem_err_o  = err_q;
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: two instances (0 and 2 wait states) driven
// by directed and random requests, checked against a word-array model.
module tb_data_mem_responder;
  import data_mem_responder_pkg::*;

  localparam int DEPTH = 1024;

  logic clk = 1'b0;
  logic rst;

  // index 0: WAIT_CYCLES=0, index 1: WAIT_CYCLES=2
  logic        ce_s    [2];
  logic        we_s    [2];
  logic [31:0] addr_s  [2];
  logic [3:0]  sel_s   [2];
  logic [31:0] wdata_s [2];
  logic [31:0] rdata_s [2];
  logic [1:0]  ack_s;
  logic [1:0]  stall_s;
  logic [1:0]  err_s;
  state_t      st_s    [2];

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] mdl [2][DEPTH];
  logic [31:0] last_data [2];
  logic [31:0] exp_q[$];

  data_mem_responder_if bus0 ();
  data_mem_responder_if bus1 ();

  assign bus0.mem_ce_i   = ce_s[0];
  assign bus0.mem_we_i   = we_s[0];
  assign bus0.mem_addr_i = addr_s[0];
  assign bus0.mem_sel_i  = sel_s[0];
  assign bus0.mem_data_i = wdata_s[0];
  assign rdata_s[0]      = bus0.mem_data_o;
  assign ack_s[0]        = bus0.mem_ack_o;
  assign stall_s[0]      = bus0.stallreq_o;
  assign err_s[0]        = bus0.mem_err_o;

  assign bus1.mem_ce_i   = ce_s[1];
  assign bus1.mem_we_i   = we_s[1];
  assign bus1.mem_addr_i = addr_s[1];
  assign bus1.mem_sel_i  = sel_s[1];
  assign bus1.mem_data_i = wdata_s[1];
  assign rdata_s[1]      = bus1.mem_data_o;
  assign ack_s[1]        = bus1.mem_ack_o;
  assign stall_s[1]      = bus1.stallreq_o;
  assign err_s[1]        = bus1.mem_err_o;

  data_mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) u_dut_w0 (
    .clk (clk), .rst (rst), .bus (bus0), .dbg_state_o (st_s[0])
  );

  data_mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(2)) u_dut_w2 (
    .clk (clk), .rst (rst), .bus (bus1), .dbg_state_o (st_s[1])
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic int wait_of(input int which);
    return (which == 0) ? 0 : 2;
  endfunction

  // Reference model: a word array with byte-lane writes and an optional range limit.
  task automatic model_access(input int which, input bit we, input logic [31:0] addr,
                              input logic [3:0] sel, input logic [31:0] wdata,
                              output logic [31:0] exp_d, output logic exp_e);
    int idx;
    bit out_of_range;
    idx = int'((addr / 4) % DEPTH);
    out_of_range = 1'b0;
`ifdef DATA_MEM_BOUND_CHECK_EN
    out_of_range = (addr >= 32'(4 * DEPTH));
`endif
    exp_e = out_of_range;
    if (out_of_range) begin
      exp_d = 32'd0;
    end else if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (sel[b]) mdl[which][idx][8*b +: 8] = wdata[8*b +: 8];
      end
      exp_d = last_data[which];
    end else begin
      exp_d = mdl[which][idx];
    end
    last_data[which] = exp_d;
  endtask

  // Entered and left at posedge+1 with the target instance idle.
  task automatic do_access(input int which, input bit we, input logic [31:0] addr,
                           input logic [3:0] sel, input logic [31:0] wdata);
    int w;
    logic [31:0] exp_d;
    logic exp_e;
    w = wait_of(which);
    model_access(which, we, addr, sel, wdata, exp_d, exp_e);
    exp_q.push_back(exp_d);
    ce_s[which]    = 1'b1;
    we_s[which]    = we;
    addr_s[which]  = addr;
    sel_s[which]   = sel;
    wdata_s[which] = wdata;
    for (int c = 0; c <= w + 1; c++) begin
      @(negedge clk);
      check_eq($sformatf("stall%0d_c%0d", which, c), stall_s[which], (c != w + 1));
      check_eq($sformatf("ack%0d_c%0d", which, c), ack_s[which], (c == w + 1));
      if (c == w + 1) begin
        check_eq($sformatf("data%0d_a%08h", which, addr), rdata_s[which], exp_q.pop_front());
        check_eq($sformatf("err%0d_a%08h", which, addr), err_s[which], exp_e);
      end
    end
    @(posedge clk); #1;
    ce_s[which] = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] a;
    int which;
    for (int i = 0; i < 2; i++) begin
      ce_s[i] = 1'b0; we_s[i] = 1'b0; addr_s[i] = '0; sel_s[i] = '0; wdata_s[i] = '0;
      last_data[i] = '0;
    end

    // reset
    rst = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check_eq($sformatf("rst_ack%0d", i), ack_s[i], 1'b0);
      check_eq($sformatf("rst_data%0d", i), rdata_s[i], 32'd0);
      check_eq($sformatf("rst_err%0d", i), err_s[i], 1'b0);
      check_eq($sformatf("rst_stall%0d", i), stall_s[i], 1'b0);
      check_eq($sformatf("rst_state%0d", i), st_s[i], ST_IDLE);
    end
    rst = 1'b1;
    idle_cycle();

    // fill the words used by the rest of the run
    for (int wd = 0; wd < 16; wd++) begin
      do_access(0, 1'b1, 32'(wd * 4), 4'hF, $urandom);
      do_access(1, 1'b1, 32'(wd * 4), 4'hF, $urandom);
    end

    // directed: full write/read, byte lane, empty select
    do_access(1, 1'b1, 32'h0000_0010, 4'b1111, 32'hDEAD_BEEF);
    do_access(1, 1'b0, 32'h0000_0010, 4'b0000, 32'h0);
    do_access(1, 1'b1, 32'h0000_0010, 4'b0100, 32'h0055_0000);
    do_access(1, 1'b0, 32'h0000_0010, 4'b1111, 32'h0);
    check_eq("byte_lane_model", mdl[1][4], 32'hDE55_BEEF);
    do_access(1, 1'b1, 32'h0000_0010, 4'b0000, 32'h1234_5678);
    do_access(1, 1'b0, 32'h0000_0012, 4'b0001, 32'h0);

    // zero wait states, back-to-back reads
    do_access(0, 1'b0, 32'h0000_0000, 4'hF, 32'h0);
    do_access(0, 1'b0, 32'h0000_0004, 4'hF, 32'h0);

    // abort by dropping ce during WAIT
    ce_s[1] = 1'b1; we_s[1] = 1'b1; addr_s[1] = 32'h10; sel_s[1] = 4'hF; wdata_s[1] = 32'hBAD0_BAD0;
    @(negedge clk);
    check_eq("abort_stall_c0", stall_s[1], 1'b1);
    @(posedge clk); #1;
    ce_s[1] = 1'b0;
    for (int c = 1; c < 5; c++) begin
      @(negedge clk);
      check_eq($sformatf("abort_ack_c%0d", c), ack_s[1], 1'b0);
      check_eq($sformatf("abort_stall_c%0d", c), stall_s[1], 1'b0);
      if (c >= 2) check_eq($sformatf("abort_state_c%0d", c), st_s[1], ST_IDLE);
    end
    idle_cycle();
    do_access(1, 1'b0, 32'h0000_0010, 4'hF, 32'h0);

    // reset during WAIT
    ce_s[1] = 1'b1; we_s[1] = 1'b1; addr_s[1] = 32'h10; sel_s[1] = 4'hF; wdata_s[1] = 32'h0BAD_F00D;
    @(negedge clk);
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check_eq("rstw_ack", ack_s[1], 1'b0);
    check_eq("rstw_data", rdata_s[1], 32'd0);
    check_eq("rstw_state", st_s[1], ST_IDLE);
    ce_s[1] = 1'b0;
    last_data[0] = '0;
    last_data[1] = '0;
    #1 rst = 1'b1;
    idle_cycle();
    do_access(1, 1'b0, 32'h0000_0010, 4'hF, 32'h0);

    // beyond-depth address: wraps or is rejected depending on build
    do_access(1, 1'b1, 32'h0000_1000, 4'hF, 32'h1111_1111);
    do_access(1, 1'b0, 32'h0000_0000, 4'hF, 32'h0);
    do_access(1, 1'b0, 32'h0000_1000, 4'hF, 32'h0);
    do_access(0, 1'b1, 32'h0000_1004, 4'hF, 32'h2222_2222);
    do_access(0, 1'b0, 32'h0000_0004, 4'hF, 32'h0);

    // random traffic
    for (int i = 0; i < 80; i++) begin
      which = $urandom_range(0, 1);
      a = 32'($urandom_range(0, 15)) << 2;
      a = a | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 5) == 0) a = a | (32'($urandom_range(1, 255)) << 12);
      do_access(which, 1'($urandom_range(0, 1)), a, 4'($urandom_range(0, 15)), $urandom);
      if ($urandom_range(0, 3) == 0) idle_cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
